// File: rtl/pneumatic_pkg.sv
// Shared types for the pneumatic cylinder plant: the cylinder state codes, the
// valve direction encoding and the state derivation used by every cylinder.
package pneumatic_pkg;

    typedef enum logic [1:0] {
        RETRACTED  = 2'd0,
        EXTENDING  = 2'd1,
        EXTENDED   = 2'd2,
        RETRACTING = 2'd3
    } cyl_state_t;

    typedef enum logic {
        RET = 1'b0,
        EXT = 1'b1
    } dir_t;

    // The state is fully determined by where the valve points and whether the
    // piston sits at the end it is heading for.
    function automatic cyl_state_t derive_state(input dir_t dir, input logic at_start,
                                                input logic at_end);
        if (dir == EXT) return at_end ? EXTENDED : EXTENDING;
        else            return at_start ? RETRACTED : RETRACTING;
    endfunction

endpackage

// File: rtl/cylinder_model.sv
// One double-acting cylinder behind a bistable 5/2 valve: direction memory,
// saturating position counter, derived state and limit switches.
// Build option PLANT_BOUNCE_EN adds contact bounce on the limit switches.
module cylinder_model
    import pneumatic_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 1000,
    parameter int BOUNCE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             plus,
    input  logic             minus,
    output logic             x0,
    output logic             x1,
    output cyl_state_t       state,
    output logic             conflict,
    output logic [CNT_W-1:0] pos
);

    localparam logic [CNT_W-1:0] POS_MAX = CNT_W'(TRAVEL_CYCLES);

    // A bad configuration stops elaboration instead of silently wrapping.
    if (TRAVEL_CYCLES < 2 || BOUNCE_CYCLES < 1 || (TRAVEL_CYCLES >> CNT_W) != 0) begin : g_param_check
        $error("cylinder_model: invalid TRAVEL_CYCLES/BOUNCE_CYCLES/CNT_W");
    end

    dir_t             dir, dir_next;
    logic [CNT_W-1:0] pos_next;
    logic             at0_next, at1_next;
    logic             x0_next, x1_next;

`ifdef PLANT_BOUNCE_EN
    localparam int BW = $clog2(BOUNCE_CYCLES + 1);
    logic [BW-1:0] bounce_cnt, bounce_cnt_next;
    logic          contact_next;
`endif

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        dir_next = dir;
        if (plus && !minus)      dir_next = EXT;
        else if (minus && !plus) dir_next = RET;

        // Motion follows the direction being latched this edge, so a reversal
        // mid-stroke moves the piston back on the same edge.
        pos_next = pos;
        if (dir_next == EXT && pos != POS_MAX)  pos_next = pos + CNT_W'(1);
        else if (dir_next == RET && pos != '0)  pos_next = pos - CNT_W'(1);

        at0_next = (pos_next == '0);
        at1_next = (pos_next == POS_MAX);

`ifdef PLANT_BOUNCE_EN
        bounce_cnt_next = bounce_cnt;
        contact_next    = x0 | x1;
        if (!(at0_next || at1_next)) begin
            bounce_cnt_next = '0;
            contact_next    = 1'b0;
        end else if (pos_next != pos) begin
            bounce_cnt_next = BW'(BOUNCE_CYCLES);
            contact_next    = 1'b1;
        end else if (bounce_cnt != '0) begin
            bounce_cnt_next = bounce_cnt - BW'(1);
            contact_next    = ~(x0 | x1);
        end else begin
            contact_next    = 1'b1;
        end
        x0_next = at0_next & contact_next;
        x1_next = at1_next & contact_next;
`else
        x0_next = at0_next;
        x1_next = at1_next;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir        <= RET;
            pos        <= '0;
            state      <= RETRACTED;
            x0         <= 1'b1;
            x1         <= 1'b0;
            conflict   <= 1'b0;
`ifdef PLANT_BOUNCE_EN
            bounce_cnt <= '0;
`endif
        end else begin
            dir        <= dir_next;
            pos        <= pos_next;
            state      <= derive_state(dir_next, at0_next, at1_next);
            x0         <= x0_next;
            x1         <= x1_next;
            conflict   <= plus & minus;
`ifdef PLANT_BOUNCE_EN
            bounce_cnt <= bounce_cnt_next;
`endif
        end
    end

endmodule

// File: rtl/pneumatic_plant.sv
// Two-cylinder pneumatic plant closing the loop around the four-slot sequencer.
// Build option PLANT_BOUNCE_EN enables limit-switch contact bounce.
module pneumatic_plant
    import pneumatic_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 1000,
    parameter int BOUNCE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Ap,
    input  logic             Am,
    input  logic             Bp,
    input  logic             Bm,
    output logic             a0,
    output logic             a1,
    output logic             b0,
    output logic             b1,
    output logic [1:0]       a_state,
    output logic [1:0]       b_state,
    output logic [1:0]       conflict,
    output logic [CNT_W-1:0] a_pos,
    output logic [CNT_W-1:0] b_pos
);

    cyl_state_t a_st, b_st;
    logic       a_conflict, b_conflict;

    cylinder_model #(
        .TRAVEL_CYCLES(TRAVEL_CYCLES),
        .BOUNCE_CYCLES(BOUNCE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_cyl_a (
        .clk     (CLK),
        .reset   (RESET),
        .plus    (Ap),
        .minus   (Am),
        .x0      (a0),
        .x1      (a1),
        .state   (a_st),
        .conflict(a_conflict),
        .pos     (a_pos)
    );

    cylinder_model #(
        .TRAVEL_CYCLES(TRAVEL_CYCLES),
        .BOUNCE_CYCLES(BOUNCE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_cyl_b (
        .clk     (CLK),
        .reset   (RESET),
        .plus    (Bp),
        .minus   (Bm),
        .x0      (b0),
        .x1      (b1),
        .state   (b_st),
        .conflict(b_conflict),
        .pos     (b_pos)
    );

    assign a_state  = a_st;
    assign b_state  = b_st;
    assign conflict = {b_conflict, a_conflict};

endmodule

// File: tb/tb_pneumatic_plant.sv
// Directed self-checking bench for pneumatic_plant with an 8-cycle stroke.
// Define PLANT_BOUNCE_EN for both RTL and bench to check the bounce burst.
module tb_pneumatic_plant;
    import pneumatic_pkg::*;

    localparam int TRAVEL = 8;
    localparam int BOUNCE = 4;
    localparam int CNT_W  = 16;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             Ap = 1'b0, Am = 1'b0, Bp = 1'b0, Bm = 1'b0;
    logic             a0, a1, b0, b1;
    logic [1:0]       a_state, b_state, conflict;
    logic [CNT_W-1:0] a_pos, b_pos;

    int checks = 0;
    int errors = 0;

    pneumatic_plant #(
        .TRAVEL_CYCLES(TRAVEL),
        .BOUNCE_CYCLES(BOUNCE),
        .CNT_W        (CNT_W)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .Ap      (Ap),
        .Am      (Am),
        .Bp      (Bp),
        .Bm      (Bm),
        .a0      (a0),
        .a1      (a1),
        .b0      (b0),
        .b1      (b1),
        .a_state (a_state),
        .b_state (b_state),
        .conflict(conflict),
        .a_pos   (a_pos),
        .b_pos   (b_pos)
    );

    always #5 CLK = ~CLK;

    // One active edge, then settle 1 time unit so outputs are sampled away from it.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        {Ap, Am, Bp, Bm} = 4'b0000;
        step();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a0, a1, b0, b1} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_sensors a0a1b0b1 got %b expected 1010", {a0, a1, b0, b1});
        end
        checks++;
        if ({a_state, b_state, conflict} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_state_conflict got %b expected 000000", {a_state, b_state, conflict});
        end
        checks++;
        if (a_pos !== 16'd0 || b_pos !== 16'd0) begin
            errors++;
            $display("FAIL reset_pos got a=%0d b=%0d expected 0 0", a_pos, b_pos);
        end
    endtask

    task automatic test_extend_hold();
        Ap = 1'b1;
        step();                                  // edge n
        Ap = 1'b0;
        checks++;
        if (a0 !== 1'b0 || a_pos !== 16'd1 || a_state !== 2'(EXTENDING)) begin
            errors++;
            $display("FAIL extend_start a0=%b pos=%0d state=%0d expected 0 1 1", a0, a_pos, a_state);
        end
        step(6);                                 // edge n+6
        checks++;
        if (a1 !== 1'b0 || a_pos !== 16'd7) begin
            errors++;
            $display("FAIL extend_before_end a1=%b pos=%0d expected 0 7", a1, a_pos);
        end
        step();                                  // edge n+7
        checks++;
        if (a1 !== 1'b1 || a_pos !== 16'd8 || a_state !== 2'(EXTENDED)) begin
            errors++;
            $display("FAIL extend_arrive a1=%b pos=%0d state=%0d expected 1 8 2", a1, a_pos, a_state);
        end
        step(20);
        checks++;
        if (a1 !== 1'b1 || a0 !== 1'b0 || a_pos !== 16'd8) begin
            errors++;
            $display("FAIL extend_hold a1=%b a0=%b pos=%0d expected 1 0 8", a1, a0, a_pos);
        end
    endtask

    task automatic test_conflict();
        Ap = 1'b1;
        Am = 1'b1;
        step();
        Ap = 1'b0;
        Am = 1'b0;
        checks++;
        if (conflict !== 2'b01) begin
            errors++;
            $display("FAIL conflict_flag got %b expected 01", conflict);
        end
        checks++;
        if (a1 !== 1'b1 || a_state !== 2'(EXTENDED) || a_pos !== 16'd8) begin
            errors++;
            $display("FAIL conflict_hold a1=%b state=%0d pos=%0d expected 1 2 8", a1, a_state, a_pos);
        end
        step();
        checks++;
        if (conflict !== 2'b00 || a_pos !== 16'd8) begin
            errors++;
            $display("FAIL conflict_clear conflict=%b pos=%0d expected 00 8", conflict, a_pos);
        end
    endtask

    // Sequencer A+ B+ A- B-: even phases issue a one-cycle command, odd phases
    // wait for the matching limit switch.
    task automatic test_closed_loop();
        int   phase;
        int   cyc;
        int   cmd_edge;
        logic sensor;
        phase    = 0;
        cyc      = 0;
        cmd_edge = 0;
        do_reset();
        for (int k = 0; k < 200 && phase < 8; k++) begin
            Ap = (phase == 0);
            Bp = (phase == 2);
            Am = (phase == 4);
            Bm = (phase == 6);
            step();
            cyc++;
            if (phase % 2 == 0) begin
                cmd_edge = cyc;
                phase++;
            end else begin
                case (phase)
                    1:       sensor = a1;
                    3:       sensor = b1;
                    5:       sensor = a0;
                    default: sensor = b0;
                endcase
                if (sensor) begin
                    checks++;
                    if (cyc - cmd_edge + 1 !== TRAVEL) begin
                        errors++;
                        $display("FAIL loop_stroke phase %0d got %0d edges expected %0d",
                                 phase, cyc - cmd_edge + 1, TRAVEL);
                    end
                    phase++;
                end
            end
        end
        {Ap, Am, Bp, Bm} = 4'b0000;
        checks++;
        if (phase !== 8) begin
            errors++;
            $display("FAIL loop_timeout reached phase %0d expected 8", phase);
        end
        checks++;
        if ({a0, a1, b0, b1} !== 4'b1010) begin
            errors++;
            $display("FAIL loop_end a0a1b0b1 got %b expected 1010", {a0, a1, b0, b1});
        end
    endtask

    task automatic test_reversal();
        logic b1_seen;
        b1_seen = 1'b0;
        Bp = 1'b1;
        step();                                  // edge n
        b1_seen |= b1;
        Bp = 1'b0;
        step(2);                                 // edge n+2
        b1_seen |= b1;
        checks++;
        if (b_pos !== 16'd3) begin
            errors++;
            $display("FAIL rev_setup b_pos got %0d expected 3", b_pos);
        end
        Bm = 1'b1;
        step();                                  // edge n+3
        b1_seen |= b1;
        Bm = 1'b0;
        checks++;
        if (b_pos !== 16'd2 || b_state !== 2'(RETRACTING)) begin
            errors++;
            $display("FAIL rev_same_edge pos=%0d state=%0d expected 2 3", b_pos, b_state);
        end
        step();                                  // edge n+4
        b1_seen |= b1;
        checks++;
        if (b0 !== 1'b0 || b_pos !== 16'd1) begin
            errors++;
            $display("FAIL rev_n4 b0=%b pos=%0d expected 0 1", b0, b_pos);
        end
        step();                                  // edge n+5
        b1_seen |= b1;
        checks++;
        if (b0 !== 1'b1 || b_pos !== 16'd0 || b_state !== 2'(RETRACTED)) begin
            errors++;
            $display("FAIL rev_return b0=%b pos=%0d state=%0d expected 1 0 0", b0, b_pos, b_state);
        end
        checks++;
        if (b1_seen !== 1'b0) begin
            errors++;
            $display("FAIL rev_b1 b1 seen %b expected 0", b1_seen);
        end
    endtask

    task automatic test_reset_mid_stroke();
        Ap = 1'b1;
        step();
        Ap = 1'b0;
        step(4);
        checks++;
        if (a_pos !== 16'd5) begin
            errors++;
            $display("FAIL mid_setup a_pos got %0d expected 5", a_pos);
        end
        RESET = 1'b1;
        Ap = 1'b1;
        Bp = 1'b1;
        step();
        RESET = 1'b0;
        Ap = 1'b0;
        Bp = 1'b0;
        checks++;
        if (a_pos !== 16'd0 || b_pos !== 16'd0 || a0 !== 1'b1 || a1 !== 1'b0 || a_state !== 2'(RETRACTED)) begin
            errors++;
            $display("FAIL mid_reset a_pos=%0d b_pos=%0d a0=%b a1=%b state=%0d expected 0 0 1 0 0",
                     a_pos, b_pos, a0, a1, a_state);
        end
    endtask

`ifdef PLANT_BOUNCE_EN
    task automatic test_bounce();
        logic [6:0] seq;
        logic [6:0] expected;
        expected = 7'b1010111;                   // first sample in the MSB
        do_reset();
        Ap = 1'b1;
        step();
        Ap = 1'b0;
        step(6);
        for (int i = 6; i >= 0; i--) begin
            step();
            seq[i] = a1;
        end
        checks++;
        if (seq !== expected) begin
            errors++;
            $display("FAIL bounce_seq a1 got %b expected %b", seq, expected);
        end
        // Leave during a fresh burst: the sensor must drop at once.
        Am = 1'b1;
        step();
        Am = 1'b0;
        Ap = 1'b1;
        step();                                  // arrive again, burst restarts
        Ap = 1'b0;
        step();
        Am = 1'b1;
        step();
        Am = 1'b0;
        checks++;
        if (a1 !== 1'b0 || a_pos !== 16'd7) begin
            errors++;
            $display("FAIL bounce_leave a1=%b pos=%0d expected 0 7", a1, a_pos);
        end
        step(20);
        checks++;
        if (a0 !== 1'b1 || a_pos !== 16'd0) begin
            errors++;
            $display("FAIL bounce_a0_settle a0=%b pos=%0d expected 1 0", a0, a_pos);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_extend_hold();
        test_conflict();
        test_closed_loop();
        test_reversal();
        test_reset_mid_stroke();
`ifdef PLANT_BOUNCE_EN
        test_bounce();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
